// File: rtl/ysyx_24080006_axi_sram_slv.sv
// rtl/ysyx_24080006_axi_sram_slv.sv - AXI-style SRAM slave with independent write and read burst channels

package ysyx_24080006_axi_sram_pkg;

  // Write-side request bundle: AW + W + B-ready (85 bits).
  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;

  // Write-side response bundle (3 bits).
  typedef struct packed {
    logic awready;
    logic wready;
    logic bvalid;
  } axi_w_s2m_t;

  // Read-side request bundle: AR + R-ready (47 bits).
  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  // Read-side response bundle (35 bits).
  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

endpackage

module ysyx_24080006_axi_sram_slv
  import ysyx_24080006_axi_sram_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  axi_w_m2s_t w_m2s,
  output axi_w_s2m_t w_s2m,
  input  axi_r_m2s_t r_m2s,
  output axi_r_s2m_t r_s2m
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  typedef logic [AW-1:0] idx_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // FIXED holds the word; every other burst code (INCR, WRAP, reserved) steps forward.
  function automatic idx_t step_idx(input idx_t idx, input logic [1:0] burst);
    return (burst == 2'b00) ? idx : idx + idx_t'(1);
  endfunction

  logic [31:0] mem [DEPTH];

  // Address translation: offset from BASE, drop the byte bits, wrap modulo DEPTH.
  logic [31:0] aw_diff;
  logic [31:0] ar_diff;
  idx_t        aw_word;
  idx_t        ar_word;
  logic        unused_bits;

  assign aw_diff = w_m2s.awaddr - BASE;
  assign ar_diff = r_m2s.araddr - BASE;
  assign aw_word = aw_diff[AW+1:2];
  assign ar_word = ar_diff[AW+1:2];
  assign unused_bits = ^{aw_diff[31:AW+2], aw_diff[1:0], ar_diff[31:AW+2], ar_diff[1:0],
                         w_m2s.awsize, w_m2s.wlast, r_m2s.arsize};

  // ---------------------------------------------------------------- write channel

  w_state_t   w_state;
  w_state_t   w_state_nxt;
  idx_t       w_idx;
  logic [7:0] w_len;
  logic [1:0] w_burst;
  logic [7:0] w_beat;
  logic       aw_hs;
  logic       w_hs;
  logic       w_last_beat;

  assign aw_hs       = w_m2s.awvalid && (w_state == W_IDLE);
  assign w_hs        = w_m2s.wvalid && (w_state == W_DATA);
  assign w_last_beat = (w_beat == w_len);

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_state_nxt   = w_state;
    w_s2m         = '0;
    w_s2m.awready = (w_state == W_IDLE);
    w_s2m.wready  = (w_state == W_DATA);
    w_s2m.bvalid  = (w_state == W_RESP);
    case (w_state)
      W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
      W_DATA: if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP: if (w_m2s.bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: target word, length, burst type and beat count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_idx   <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_beat  <= '0;
    end else if (aw_hs) begin
      w_idx   <= aw_word;
      w_len   <= w_m2s.awlen;
      w_burst <= w_m2s.awburst;
      w_beat  <= '0;
    end else if (w_hs) begin
      w_idx <= step_idx(w_idx, w_burst);
      if (!w_last_beat) begin
        w_beat <= w_beat + 8'd1;
      end
    end
  end

  // Storage write port: byte-lane merge under wstrb; the array itself is never reset.
  always_ff @(posedge clock) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (w_m2s.wstrb[i]) begin
          mem[w_idx][8*i +: 8] <= w_m2s.wdata[8*i +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read channel

  r_state_t    r_state;
  r_state_t    r_state_nxt;
  idx_t        r_idx;
  idx_t        r_idx_nxt;
  idx_t        rd_idx;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;
  logic [7:0]  r_beat;
  logic [3:0]  r_cnt;
  logic [31:0] rdata_q;
  logic        rlast_q;
  logic [31:0] rd_word;
  logic        ar_hs;
  logic        r_hs;
  logic        r_last_beat;

  assign ar_hs       = r_m2s.arvalid && (r_state == R_IDLE);
  assign r_hs        = r_m2s.rready && (r_state == R_DATA);
  assign r_last_beat = (r_beat == r_len);
  assign r_idx_nxt   = step_idx(r_idx, r_burst);

  // Read fetch address: the new burst start in idle, the held start while waiting,
  // and the following beat while streaming so it lands the cycle after a handshake.
  always_comb begin
    rd_idx = r_idx;
    case (r_state)
      R_IDLE:  rd_idx = ar_word;
      R_WAIT:  rd_idx = r_idx;
      R_DATA:  rd_idx = r_idx_nxt;
      default: rd_idx = r_idx;
    endcase
  end

  // Asynchronous array read; a write on the same edge lands afterwards, so old data wins.
  assign rd_word = mem[rd_idx];

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  // Read FSM next state and channel outputs.
  always_comb begin
    r_state_nxt   = r_state;
    r_s2m         = '0;
    r_s2m.arready = (r_state == R_IDLE);
    r_s2m.rvalid  = (r_state == R_DATA);
    r_s2m.rdata   = rdata_q;
    r_s2m.rlast   = rlast_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_nxt = (RD_LAT > 0) ? R_WAIT : R_DATA;
        end
      end
      R_WAIT: if (r_cnt == 4'd1) r_state_nxt = R_DATA;
      R_DATA: if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst bookkeeping and the registered rdata/rlast presented on R.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx   <= ar_word;
            r_len   <= r_m2s.arlen;
            r_burst <= r_m2s.arburst;
            r_beat  <= '0;
            r_cnt   <= RD_LAT_C;
            if (RD_LAT == 0) begin
              rdata_q <= rd_word;
              rlast_q <= (r_m2s.arlen == 8'd0);
            end
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            rdata_q <= rd_word;
            rlast_q <= (r_len == 8'd0);
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last_beat) begin
              rlast_q <= 1'b0;
            end else begin
              r_idx   <= r_idx_nxt;
              r_beat  <= r_beat + 8'd1;
              rdata_q <= rd_word;
              rlast_q <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: begin
          rlast_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slv.sv
// tb/tb_ysyx_24080006_axi_sram_slv.sv - directed self-checking bench for the AXI SRAM slave

module tb_ysyx_24080006_axi_sram_slv;
  import ysyx_24080006_axi_sram_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [1:0]  WRAP  = 2'b10;

  logic       clock = 1'b0;
  logic       reset_n;
  axi_w_m2s_t w_m2s;
  axi_w_s2m_t w_s2m;
  axi_r_m2s_t r_m2s;
  axi_r_s2m_t r_s2m;

  int checks = 0;
  int failures = 0;

  logic [31:0] wbuf [256];
  logic [31:0] rexp [256];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  ysyx_24080006_axi_sram_slv #(
    .BASE   (BASE),
    .DEPTH  (DEPTH),
    .RD_LAT (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .w_m2s   (w_m2s),
    .w_s2m   (w_s2m),
    .r_m2s   (r_m2s),
    .r_s2m   (r_s2m)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outs;
    chk1("rst_awready", w_s2m.awready, 1'b1);
    chk1("rst_arready", r_s2m.arready, 1'b1);
    chk1("rst_wready",  w_s2m.wready,  1'b0);
    chk1("rst_bvalid",  w_s2m.bvalid,  1'b0);
    chk1("rst_rvalid",  r_s2m.rvalid,  1'b0);
    chk1("rst_rlast",   r_s2m.rlast,   1'b0);
    chk ("rst_rdata",   r_s2m.rdata,   32'h0);
  endtask

  // Write burst of len+1 beats from wbuf; bvalid must appear right after the last
  // beat and stay up for bhold cycles of bready=0.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int bhold);
    chk1("aw_ready_idle", w_s2m.awready, 1'b1);
    w_m2s.awvalid = 1'b1;
    w_m2s.awaddr  = addr;
    w_m2s.awlen   = len;
    w_m2s.awburst = burst;
    w_m2s.awsize  = 3'd2;
    tick();
    w_m2s.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      chk1("w_ready", w_s2m.wready, 1'b1);
      w_m2s.wvalid = 1'b1;
      w_m2s.wdata  = wbuf[i];
      w_m2s.wstrb  = strb;
      w_m2s.wlast  = (i == int'(len));
      tick();
    end
    w_m2s.wvalid = 1'b0;
    w_m2s.wlast  = 1'b0;
    for (int i = 0; i < bhold; i++) begin
      chk1("b_valid_hold", w_s2m.bvalid, 1'b1);
      tick();
    end
    chk1("b_valid", w_s2m.bvalid, 1'b1);
    w_m2s.bready = 1'b1;
    tick();
    w_m2s.bready = 1'b0;
    chk1("b_valid_clear", w_s2m.bvalid, 1'b0);
    chk1("aw_ready_back", w_s2m.awready, 1'b1);
  endtask

  // Read burst of len+1 beats compared against rexp; toggle applies rready 1,0,0,1.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    logic [3:0]  pat;
    logic [31:0] hold_d;
    logic        hold_l;
    logic        rr;
    int          lat;
    int          beat;
    int          cyc;
    pat = 4'b1001;
    chk1("ar_ready_idle", r_s2m.arready, 1'b1);
    r_m2s.arvalid = 1'b1;
    r_m2s.araddr  = addr;
    r_m2s.arlen   = len;
    r_m2s.arburst = burst;
    r_m2s.arsize  = 3'd2;
    tick();
    r_m2s.arvalid = 1'b0;
    lat = 1;
    while (!r_s2m.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    chk("r_latency", 32'(lat), 32'd3);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 2000) begin
      rr = toggle ? pat[cyc % 4] : 1'b1;
      r_m2s.rready = rr;
      chk1("r_valid_in_burst", r_s2m.rvalid, 1'b1);
      hold_d = r_s2m.rdata;
      hold_l = r_s2m.rlast;
      if (rr) begin
        chk ("r_data",  r_s2m.rdata, rexp[beat]);
        chk1("r_last",  r_s2m.rlast, (beat == int'(len)));
        beat++;
      end
      tick();
      if (!rr) begin
        chk ("r_data_stable", r_s2m.rdata, hold_d);
        chk1("r_last_stable", r_s2m.rlast, hold_l);
      end
      cyc++;
    end
    r_m2s.rready = 1'b0;
    chk("r_beats", 32'(beat), 32'(int'(len) + 1));
    chk1("r_valid_done",  r_s2m.rvalid,  1'b0);
    chk1("r_last_done",   r_s2m.rlast,   1'b0);
    chk1("ar_ready_back", r_s2m.arready, 1'b1);
  endtask

  task automatic read1(input logic [31:0] addr, input logic [31:0] exp);
    rexp[0] = exp;
    do_read(addr, 8'd0, INCR, 1'b0);
  endtask

  initial begin
    w_m2s   = '0;
    r_m2s   = '0;
    reset_n = 1'b0;

    vecs[0] = '{BASE + 32'd8,                    32'hDEADBEEF, 4'hF, BASE + 32'd8,  32'hDEADBEEF};
    vecs[1] = '{BASE + 32'd16,                   32'h11223344, 4'hF, BASE + 32'd16, 32'h11223344};
    vecs[2] = '{BASE + 32'd16,                   32'hAABBCCDD, 4'h5, BASE + 32'd16, 32'h11BB33DD};
    vecs[3] = '{BASE + 32'd16,                   32'h00000000, 4'h0, BASE + 32'd16, 32'h11BB33DD};
    vecs[4] = '{BASE + 32'(4 * DEPTH) + 32'd20,  32'hCAFEF00D, 4'hF, BASE + 32'd20, 32'hCAFEF00D};
    vecs[5] = '{BASE + 32'd24,                   32'hFFFFFFFF, 4'hF, BASE + 32'd24, 32'hFFFFFFFF};
    vecs[6] = '{BASE + 32'd24,                   32'h12345678, 4'hA, BASE + 32'd24, 32'h12FF56FF};

    repeat (2) @(posedge clock);
    #1;
    chk_reset_outs();
    reset_n = 1'b1;
    tick();

    // Single-beat write/readback table.
    for (int i = 0; i < 7; i++) begin
      wbuf[0] = vecs[i].wdata;
      do_write(vecs[i].waddr, 8'd0, INCR, vecs[i].wstrb, 0);
      read1(vecs[i].raddr, vecs[i].exp);
    end

    // INCR burst wrapping past the top of the array.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(BASE + 32'(4 * (DEPTH - 2)), 8'd3, INCR, 4'hF, 0);
    read1(BASE + 32'(4 * (DEPTH - 2)), 32'd1);
    read1(BASE + 32'(4 * (DEPTH - 1)), 32'd2);
    read1(BASE,                        32'd3);
    read1(BASE + 32'd4,                32'd4);
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i + 1);
    do_read(BASE + 32'(4 * (DEPTH - 2)), 8'd3, INCR, 1'b0);

    // FIXED burst stays on one word; WRAP advances like INCR.
    wbuf[0] = 32'hAAAA0000;
    wbuf[1] = 32'hAAAA0001;
    do_write(BASE + 32'd160, 8'd1, INCR, 4'hF, 0);
    wbuf[0] = 32'd7; wbuf[1] = 32'd8; wbuf[2] = 32'd9;
    do_write(BASE + 32'd160, 8'd2, FIXED, 4'hF, 0);
    read1(BASE + 32'd164, 32'hAAAA0001);
    for (int i = 0; i < 3; i++) rexp[i] = 32'd9;
    do_read(BASE + 32'd160, 8'd2, FIXED, 1'b0);
    wbuf[0] = 32'h44; wbuf[1] = 32'h45;
    do_write(BASE + 32'd176, 8'd1, WRAP, 4'hF, 0);
    rexp[0] = 32'h44; rexp[1] = 32'h45;
    do_read(BASE + 32'd176, 8'd1, INCR, 1'b0);

    // Eight-beat read with rready back-pressure.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    do_write(BASE + 32'h100, 8'd7, INCR, 4'hF, 0);
    for (int i = 0; i < 8; i++) rexp[i] = 32'h1000 + 32'(i);
    do_read(BASE + 32'h100, 8'd7, INCR, 1'b1);

    // Concurrent write (bready held low 5 cycles) and read on disjoint words.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h2000 + 32'(i);
    fork
      do_write(BASE + 32'h200, 8'd3, INCR, 4'hF, 5);
      do_read(BASE + 32'h100, 8'd7, INCR, 1'b0);
    join
    for (int i = 0; i < 4; i++) rexp[i] = 32'h2000 + 32'(i);
    do_read(BASE + 32'h200, 8'd3, INCR, 1'b0);

    // Reset mid-burst on both channels.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(BASE + 32'h300, 8'd3, INCR, 4'hF, 0);
    r_m2s.arvalid = 1'b1;
    r_m2s.araddr  = BASE + 32'h100;
    r_m2s.arlen   = 8'd3;
    r_m2s.arburst = INCR;
    tick();
    r_m2s.arvalid = 1'b0;
    tick();
    tick();
    chk1("mid_rvalid", r_s2m.rvalid, 1'b1);
    chk ("mid_rdata",  r_s2m.rdata,  32'h1000);
    w_m2s.awvalid = 1'b1;
    w_m2s.awaddr  = BASE + 32'h300;
    w_m2s.awlen   = 8'd3;
    w_m2s.awburst = INCR;
    tick();
    w_m2s.awvalid = 1'b0;
    w_m2s.wvalid  = 1'b1;
    w_m2s.wstrb   = 4'hF;
    w_m2s.wdata   = 32'hB0;
    tick();
    w_m2s.wdata   = 32'hB1;
    tick();
    w_m2s.wdata   = 32'hB2;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    tick();
    chk_reset_outs();
    w_m2s.wvalid = 1'b0;
    reset_n = 1'b1;
    tick();
    read1(BASE + 32'h300, 32'hB0);
    read1(BASE + 32'h304, 32'hB1);
    read1(BASE + 32'h308, 32'hA2);
    read1(BASE + 32'h30C, 32'hA3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_axi_sram_slv.md
YSYX_24080006_AXI_SRAM_SLV -- requirements
Module: ysyx_24080006_axi_sram_slv

Interface
REQ-001 SHALL have parameter BASE, 32'h8000_0000, byte address mapped to word 0.
REQ-002 SHALL have parameter DEPTH, 4096, number of 32-bit words (power of two).
REQ-003 SHALL have parameter RD_LAT, 2, idle cycles between AR handshake and first R beat (0..15).
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port w_m2s  input  axi_w_m2s_t (85)  AW/W/B request fields from initiator.
REQ-007 SHALL have port w_s2m  output  axi_w_s2m_t (3)  awready, wready, bvalid.
REQ-008 SHALL have port r_m2s  input  axi_r_m2s_t (47)  AR/R request fields from initiator.
REQ-009 SHALL have port r_s2m  output  axi_r_s2m_t (35)  arready, rvalid, rdata, rlast.

Function
REQ-010 SHALL hold a DEPTH x 32 storage array with one write port and one read port; read and write channels SHALL run fully independently.
REQ-011 SHALL map byte address A to word index ((A - BASE) >> 2) mod DEPTH; out-of-range addresses wrap, no error.
REQ-012 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-013 W_IDLE: on awvalid&awready SHALL latch word index, awlen, awburst, clear beat counter, go to W_DATA next cycle.
REQ-014 W_DATA: each wvalid&wready cycle SHALL write byte lane i of wdata where wstrb[i]=1, leaving other lanes unchanged.
REQ-015 After each W beat, index SHALL increment by 1 (mod DEPTH) when burst=INCR (2'b01), stay fixed when FIXED (2'b00); WRAP (2'b10) SHALL be treated as INCR.
REQ-016 W_DATA SHALL exit to W_RESP after beat awlen+1 accepted; termination SHALL use the beat counter only, wlast ignored.
REQ-017 W_RESP: bvalid SHALL stay 1 until bready; on bvalid&bready SHALL return to W_IDLE next cycle (awready=1).
REQ-018 Read FSM states SHALL be R_IDLE, R_WAIT, R_DATA; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-019 R_IDLE: on arvalid&arready SHALL latch index, arlen, arburst; go to R_WAIT when RD_LAT>0 (counter loaded RD_LAT), else directly R_DATA.
REQ-020 R_WAIT SHALL decrement counter each cycle and enter R_DATA the cycle after it reaches 1; first rvalid appears exactly RD_LAT+1 cycles after AR handshake.
REQ-021 R_DATA: rdata and rlast SHALL be registered and stable while rvalid=1 and rready=0.
REQ-022 rlast SHALL be 1 exactly on beat arlen (zero-based); on rvalid&rready of non-last beat next beat SHALL be presented the following cycle with no latency wait; index advances per REQ-015.
REQ-023 On handshake of last beat SHALL return to R_IDLE next cycle with rvalid=0, rlast=0.
REQ-024 Same-cycle write and read-fetch to same word SHALL return the pre-write data.
REQ-025 awsize/arsize SHALL be ignored; every beat is 4 bytes, narrowing only via wstrb.
REQ-026 awlen/arlen range 0..255 SHALL be supported; beat counters SHALL be 8 bits with no overflow past awlen/arlen.

Reset
REQ-027 While reset_n=0 both FSMs SHALL be IDLE: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0.
REQ-028 Reset asserted mid-burst SHALL abort both channels immediately; beats already written remain in storage; storage array SHALL NOT be reset.

Verification
REQ-029 Single write awaddr=BASE+8, awlen=0, wdata=32'hDEADBEEF, wstrb=4'hF, then read araddr=BASE+8, arlen=0 -> bvalid one cycle after W beat; rvalid 3 cycles after AR handshake (RD_LAT=2), rdata=32'hDEADBEEF, rlast=1.
REQ-030 Partial strobe: word preloaded 32'h11223344, write wdata=32'hAABBCCDD wstrb=4'b0101 -> readback 32'h11BB33DD.
REQ-031 INCR burst awlen=3 at BASE+4*(DEPTH-2), data 1,2,3,4 -> words DEPTH-2, DEPTH-1, 0, 1 hold 1,2,3,4; 4-beat read returns 1,2,3,4 with rlast only on 4th beat.
REQ-032 Read burst arlen=7 with rready toggled 1,0,0,1 pattern -> rdata/rlast unchanged during rready=0, exactly 8 beats delivered in order, arready=1 cycle after last handshake.
REQ-033 Concurrent write burst and read burst on disjoint addresses, bready held 0 for 5 cycles -> bvalid held 5 cycles, read burst completes unaffected.
REQ-034 reset_n pulled low after beat 2 of a 4-beat write -> all outputs at REQ-027 values within same cycle; beats 1-2 readable after reset, words 3-4 unchanged.
